hyper_rx_ctrl: RTL and testbench

Sequences the HyperBus read-data capture path for one read burst at a time.
- After the command/address phase, counts the initial latency, then enables the DDR input capture stage.
- Counts received 16-bit words from the PHY strobe and buffers them in a small FIFO with a valid/ready output toward the system side.
- Flags a timeout if the device stops strobing, and flags an overflow if the FIFO is full when a word arrives.
- Sits between the transaction FSM (command issue) and the DDR input register pair. Runs entirely in the clk_i domain; rx_valid_i/rx_data_i arrive already synchronized.

---
 rtl/hyper_rx_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_hyper_rx_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hyper_rx_ctrl.sv
// HyperBus read-data capture sequencer.
// Waits out the initial latency after a read command, enables the DDR capture
// stage, counts strobed 16-bit words into a small FIFO toward the system side,
// and reports a strobe timeout or a FIFO overflow as sticky error flags.
module hyper_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned LAT_W      = 5,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [LAT_W-1:0] cmd_lat_i,
    output logic             rx_en_o,
    input  logic             rx_valid_i,
    input  logic [15:0]      rx_data_i,
    output logic [15:0]      rdata_o,
    output logic             rdata_valid_o,
    input  logic             rdata_ready_i,
    output logic             rdata_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_timeout_o,
    output logic             err_overflow_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_LAT = 2'd1,
        S_RECV     = 2'd2,
        S_FINISH   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [LEN_W:0]   word_cnt_q, word_cnt_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             err_to_q, err_to_d;
    logic             err_ovf_q, err_ovf_d;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [15:0]      mem_data_q [FIFO_DEPTH];
    logic             mem_last_q [FIFO_DEPTH];

    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             fifo_rd_s;
    logic             fifo_wr_s;
    logic             wr_last_s;

    // Wrap-bit pointer compare: equal pointers mean empty, equal index with
    // differing wrap bit means full.
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_rd_s    = !fifo_empty_s && rdata_ready_i;

    // Next-state logic: latency countdown, word/timeout counting, error capture.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        lat_cnt_d  = lat_cnt_q;
        word_cnt_d = word_cnt_q;
        to_cnt_d   = to_cnt_q;
        err_to_d   = err_to_q;
        err_ovf_d  = err_ovf_q;
        fifo_wr_s  = 1'b0;
        wr_last_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d    = S_WAIT_LAT;
                    len_d      = cmd_len_i;
                    lat_cnt_d  = cmd_lat_i;
                    word_cnt_d = '0;
                    to_cnt_d   = '0;
                    err_to_d   = 1'b0;
                    err_ovf_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT_LAT: begin
                // Strobes are ignored here; the capture stage is not enabled yet.
                if (lat_cnt_q == '0) begin
                    state_d  = S_RECV;
                    to_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end

            S_RECV: begin
                if (rx_valid_i) begin
                    word_cnt_d = word_cnt_q + (LEN_W + 1)'(1);
                    to_cnt_d   = '0;
                    wr_last_s  = (word_cnt_q == {1'b0, len_q});
                    // A read in the same cycle frees a slot, so a full FIFO
                    // can still take the word.
                    if (!fifo_full_s || fifo_rd_s) begin
                        fifo_wr_s = 1'b1;
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                    if (wr_last_s) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_RECV;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = S_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            lat_cnt_q  <= '0;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            err_to_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            lat_cnt_q  <= lat_cnt_d;
            word_cnt_q <= word_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_to_q   <= err_to_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    // FIFO pointer advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_wr_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (fifo_rd_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // FIFO pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the head outputs start at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_data_q[i] <= 16'h0000;
                mem_last_q[i] <= 1'b0;
            end
        end else if (fifo_wr_s) begin
            mem_data_q[wr_ptr_q[AW-1:0]] <= rx_data_i;
            mem_last_q[wr_ptr_q[AW-1:0]] <= wr_last_s;
        end
    end

    assign cmd_ready_o    = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign rx_en_o        = (state_q == S_RECV);
    assign done_o         = (state_q == S_FINISH);
    assign err_timeout_o  = err_to_q;
    assign err_overflow_o = err_ovf_q;
    assign rdata_valid_o  = !fifo_empty_s;
    assign rdata_o        = mem_data_q[rd_ptr_q[AW-1:0]];
    assign rdata_last_o   = mem_last_q[rd_ptr_q[AW-1:0]] && !fifo_empty_s;

endmodule

// File: tb/tb_hyper_rx_ctrl.sv
// Randomized bench for hyper_rx_ctrl against a timestamp-based reference model.
module tb_hyper_rx_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [7:0]  cmd_len_i = 8'd0;
    logic [4:0]  cmd_lat_i = 5'd0;
    logic        rx_en_o;
    logic        rx_valid_i = 1'b0;
    logic [15:0] rx_data_i = 16'h0000;
    logic [15:0] rdata_o;
    logic        rdata_valid_o;
    logic        rdata_ready_i = 1'b0;
    logic        rdata_last_o;
    logic        busy_o;
    logic        done_o;
    logic        err_timeout_o;
    logic        err_overflow_o;

    hyper_rx_ctrl #(
        .FIFO_DEPTH(DEPTH), .LEN_W(8), .LAT_W(5), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_len_i(cmd_len_i), .cmd_lat_i(cmd_lat_i),
        .rx_en_o(rx_en_o), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .rdata_ready_i(rdata_ready_i), .rdata_last_o(rdata_last_o),
        .busy_o(busy_o), .done_o(done_o),
        .err_timeout_o(err_timeout_o), .err_overflow_o(err_overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: burst timing expressed as absolute cycle numbers.
    typedef struct packed { logic last; logic [15:0] data; } ent_t;
    ent_t q[$];
    int  cyc = 0;
    bit  m_busy = 1'b0;
    bit  m_ended = 1'b0;
    int  m_recv_start = 0;
    int  m_fin_cyc = -1;
    int  m_words = 0;
    int  m_len = 0;
    int  m_last_ref = 0;
    bit  m_to = 1'b0;
    bit  m_ovf = 1'b0;

    function automatic bit in_recv();
        return m_busy && !m_ended && (cyc >= m_recv_start);
    endfunction

    task automatic check_outputs();
        chk_eq("cmd_ready", cmd_ready_o, !m_busy);
        chk_eq("busy", busy_o, m_busy);
        chk_eq("rx_en", rx_en_o, in_recv());
        chk_eq("done", done_o, (cyc == m_fin_cyc));
        chk_eq("err_timeout", err_timeout_o, m_to);
        chk_eq("err_overflow", err_overflow_o, m_ovf);
        chk_eq("rdata_valid", rdata_valid_o, (q.size() != 0));
        if (q.size() != 0) begin
            chk_eq("rdata", rdata_o, q[0].data);
            chk_eq("rdata_last", rdata_last_o, q[0].last);
        end
    endtask

    task automatic model_update();
        bit   was_busy;
        bit   recv;
        bit   last;
        ent_t e;
        was_busy = m_busy;
        recv     = in_recv();
        if (rdata_ready_i && q.size() > 0) void'(q.pop_front());
        if (recv) begin
            if (rx_valid_i) begin
                last = (m_words == m_len);
                e.last = last;
                e.data = rx_data_i;
                if (q.size() < DEPTH) q.push_back(e);
                else m_ovf = 1'b1;
                m_words++;
                m_last_ref = cyc + 1;
                if (last) begin
                    m_ended   = 1'b1;
                    m_fin_cyc = cyc + 1;
                end
            end else if (cyc - m_last_ref + 1 == TIMEOUT) begin
                m_to      = 1'b1;
                m_ended   = 1'b1;
                m_fin_cyc = cyc + 1;
            end
        end
        if (was_busy && cyc == m_fin_cyc) m_busy = 1'b0;
        if (!was_busy && cmd_valid_i) begin
            m_busy       = 1'b1;
            m_ended      = 1'b0;
            m_words      = 0;
            m_len        = int'(cmd_len_i);
            m_recv_start = cyc + int'(cmd_lat_i) + 2;
            m_last_ref   = m_recv_start;
            m_to         = 1'b0;
            m_ovf        = 1'b0;
            m_fin_cyc    = -1;
        end
        cyc++;
    endtask

    // One clock: check at negedge, drive random inputs, update model at posedge.
    task automatic step(input int p_cmd, input int p_valid, input int p_ready,
                        input int len_lo, input int len_hi, input int lat_hi);
        check_outputs();
        cmd_valid_i   = ($urandom_range(0, 99) < p_cmd);
        cmd_len_i     = 8'($urandom_range(len_lo, len_hi));
        cmd_lat_i     = 5'($urandom_range(0, lat_hi));
        rx_valid_i    = ($urandom_range(0, 99) < p_valid);
        rx_data_i     = 16'($urandom);
        rdata_ready_i = ($urandom_range(0, 99) < p_ready);
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic check_reset_values();
        chk_eq("rst_cmd_ready", cmd_ready_o, 1'b1);
        chk_eq("rst_rx_en", rx_en_o, 1'b0);
        chk_eq("rst_rdata_valid", rdata_valid_o, 1'b0);
        chk_eq("rst_rdata_last", rdata_last_o, 1'b0);
        chk_eq("rst_busy", busy_o, 1'b0);
        chk_eq("rst_done", done_o, 1'b0);
        chk_eq("rst_err_timeout", err_timeout_o, 1'b0);
        chk_eq("rst_err_overflow", err_overflow_o, 1'b0);
    endtask

    // Asynchronous reset pulse taken between clock edges.
    task automatic mid_reset();
        #2 rst_ni = 1'b0;
        #1 check_reset_values();
        q.delete();
        m_busy = 1'b0; m_ended = 1'b0; m_fin_cyc = -1;
        m_to = 1'b0; m_ovf = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        #1 check_reset_values();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Mixed traffic, short bursts.
        for (int i = 0; i < 1500; i++) step(50, 60, 50, 0, 15, 7);

        // Heavy backpressure: overflow.
        for (int i = 0; i < 800; i++) step(60, 90, 10, 4, 12, 3);

        // Sparse strobes: timeouts.
        for (int i = 0; i < 800; i++) step(70, 3, 60, 3, 20, 5);

        // Drain, then build a 3-word FIFO mid-burst and reset.
        for (int i = 0; i < 40; i++) step(0, 0, 100, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            if (in_recv() && q.size() == 3) break;
            step(100, 100, 0, 15, 15, 1);
        end
        chk_eq("pre_reset_fifo3", rdata_valid_o && rx_en_o, (q.size() == 3) && in_recv());
        mid_reset();

        // Long bursts without backpressure, including len=255.
        for (int i = 0; i < 1500; i++) step(100, 100, 100, 200, 255, 31);

        // Back-to-back commands with draining FIFO.
        for (int i = 0; i < 1000; i++) step(100, 80, 40, 0, 6, 2);

        check_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
